// File: rtl/membrane_ctrl.sv
// Membrane type sequencer: debounced cycle/freeze buttons step NONE->MAGENTA->RED->BLUE
// through a frame-aligned settle window with the membrane dropped.

module membrane_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic [23:0] cnt_q, cnt_d;
  logic        acc_q, acc_d, acc_dly_q;

  // Count consecutive samples that disagree with the accepted level; any agreement restarts.
  always_comb begin
    cnt_d = '0;
    acc_d = acc_q;
    if (sync_q[1] != acc_q) begin
      if (cnt_q == DB_LAST) acc_d = sync_q[1];
      else                  cnt_d = cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      acc_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
    end
  end

  assign press_o = acc_q & ~acc_dly_q;
endmodule

module membrane_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SETTLE_FRAMES   = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame,
  input  logic btnC,
  input  logic btnU,
  output logic no_membrane,
  output logic magenta_membrane,
  output logic red_membrane,
  output logic blue_membrane,
  output logic membrane_on,
  output logic freeze,
  output logic busy
);
  localparam logic [7:0] ST_LAST = 8'(SETTLE_FRAMES - 1);

  typedef enum logic {IDLE, DROP} state_e;

  state_e     state_q, state_d;
  logic [1:0] type_q, type_d, next_q, next_d;
  logic [7:0] cnt_q, cnt_d;
  logic       on_q, on_d, frz_q, frz_d;
  logic       cyc_pend_q, cyc_pend_d, frz_pend_q, frz_pend_d;
  logic [1:0] press;
  logic       cyc_eff, frz_eff, frz_new, enter, done;

  // press[0] = cycle button, press[1] = freeze button
  membrane_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clk    (clk),
    .reset  (reset),
    .btn_i  ({btnU, btnC}),
    .press_o(press)
  );

  // A press coinciding with a frame is consumed on that frame; freeze resolves first.
  always_comb begin
    cyc_eff = cyc_pend_q | press[0];
    frz_eff = frz_pend_q | press[1];
    frz_new = frz_q ^ frz_eff;
    enter   = frame && (state_q == IDLE) && cyc_eff && !frz_new;
    done    = frame && (state_q == DROP) && !frz_new && (cnt_q == ST_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enter) state_d = DROP;
      DROP:    if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_pend_d = cyc_eff;
    frz_pend_d = frz_eff;
    frz_d      = frz_q;
    type_d     = type_q;
    next_d     = next_q;
    on_d       = on_q;
    cnt_d      = cnt_q;
    if (frame) begin
      frz_pend_d = 1'b0;
      frz_d      = frz_new;
      if (enter) begin
        next_d     = type_q + 2'd1;
        on_d       = 1'b0;
        cnt_d      = '0;
        cyc_pend_d = 1'b0;
      end else if (done) begin
        type_d = next_q;
        on_d   = (next_q != 2'd0);
      end else if (state_q == DROP && !frz_new) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q     <= 2'd0;
      next_q     <= 2'd0;
      cnt_q      <= '0;
      on_q       <= 1'b0;
      frz_q      <= 1'b0;
      cyc_pend_q <= 1'b0;
      frz_pend_q <= 1'b0;
    end else begin
      type_q     <= type_d;
      next_q     <= next_d;
      cnt_q      <= cnt_d;
      on_q       <= on_d;
      frz_q      <= frz_d;
      cyc_pend_q <= cyc_pend_d;
      frz_pend_q <= frz_pend_d;
    end
  end

  always_comb begin
    no_membrane      = (type_q == 2'd0);
    magenta_membrane = (type_q == 2'd1);
    red_membrane     = (type_q == 2'd2);
    blue_membrane    = (type_q == 2'd3);
    membrane_on      = on_q;
    freeze           = frz_q;
    busy             = (state_q == DROP);
  end
endmodule

// File: tb/tb_membrane_ctrl.sv
// Randomized scoreboard bench for membrane_ctrl against a frame-level reference model.

module tb_membrane_ctrl;
  localparam int DB = 4, ST = 3, FP = 50;
  localparam logic [6:0] RST_VEC = 7'b1000000;

  logic clk = 1'b0, reset = 1'b1, frame = 1'b0, btnC = 1'b0, btnU = 1'b0;
  logic no_m, mag_m, red_m, blue_m, mon, frz, busy;
  logic frame_seen = 1'b0;

  membrane_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_FRAMES(ST)) dut (
    .clk(clk), .reset(reset), .frame(frame), .btnC(btnC), .btnU(btnU),
    .no_membrane(no_m), .magenta_membrane(mag_m), .red_membrane(red_m),
    .blue_membrane(blue_m), .membrane_on(mon), .freeze(frz), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [6:0] exp_q[$];
  logic [6:0] cur_exp = RST_VEC;

  // Reference model: type number, frames still to wait, sticky request bits.
  int m_type = 0, m_next = 0, m_left = 0;
  bit m_on = 0, m_frz = 0, m_busy = 0, m_cp = 0, m_fp = 0;

  function automatic logic [6:0] model_vec();
    return {m_type == 0, m_type == 1, m_type == 2, m_type == 3, m_on, m_frz, m_busy};
  endfunction

  function automatic logic [6:0] outvec();
    return {no_m, mag_m, red_m, blue_m, mon, frz, busy};
  endfunction

  task automatic model_reset();
    m_type = 0; m_next = 0; m_left = 0;
    m_on = 0; m_frz = 0; m_busy = 0; m_cp = 0; m_fp = 0;
  endtask

  task automatic model_frame();
    if (m_fp) begin m_frz = !m_frz; m_fp = 0; end
    if (!m_busy) begin
      if (m_cp && !m_frz) begin
        m_cp = 0; m_busy = 1; m_on = 0; m_left = ST; m_next = (m_type + 1) % 4;
      end
    end else if (!m_frz) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_busy = 0; m_type = m_next; m_on = (m_type != 0); end
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b (no,mag,red,blue,on,frz,busy) at %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    int fcnt = 0;
    forever begin
      @(negedge clk);
      fcnt++;
      frame = (fcnt % FP == 0);
    end
  end

  always @(posedge clk) frame_seen <= frame & ~reset;

  always @(posedge clk) begin
    if (!reset && frame) begin
      model_frame();
      exp_q.push_back(model_vec());
    end
  end

  // Monitor: pop one expectation per frame, and re-check mid-interval for stability.
  initial begin
    int since = 0;
    forever begin
      @(negedge clk);
      if (reset) since = 0;
      else if (frame_seen) begin
        since = 0;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_empty: got %b expected a queued value", outvec());
        end else begin
          cur_exp = exp_q.pop_front();
          check("frame_update", outvec(), cur_exp);
        end
      end else begin
        since++;
        if (since == 25) check("between_frames", outvec(), cur_exp);
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_seen && n < 3 * FP);
    if (!frame_seen) begin
      tests++; fails++;
      $display("FAIL frame_timeout: got no frame expected one within %0d cycles", 3 * FP);
    end
  endtask

  task automatic idle_frames(input int n);
    repeat (n) wait_frame();
  endtask

  task automatic press(input bit c, input bit u, input bit bounce);
    wait_frame();
    repeat (3) @(negedge clk);
    if (c) m_cp = 1;
    if (u) m_fp = 1;
    if (bounce && c) begin
      repeat (10) begin btnC = ~btnC; repeat (2) @(negedge clk); end
    end
    btnC = c; btnU = u;
    repeat (10) @(negedge clk);
    btnC = 1'b0; btnU = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", outvec(), RST_VEC);
    model_reset();
    exp_q.delete();
    cur_exp = RST_VEC;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_init", outvec(), RST_VEC);
    #2 reset = 1'b0;

    press(1, 0, 0); idle_frames(4);                 // MAGENTA
    repeat (3) begin press(1, 0, 0); idle_frames(4); end  // RED, BLUE, NONE
    press(1, 0, 1); idle_frames(4);                 // bounce -> single step
    press(1, 0, 0); wait_frame();                   // enter DROP
    press(0, 1, 0); idle_frames(5);                 // freeze after one counted frame
    press(0, 1, 0); idle_frames(3);                 // unfreeze, completes
    press(1, 1, 0); idle_frames(2);                 // freeze blocks entry
    press(0, 1, 0); idle_frames(4);                 // unfreeze services request
    press(1, 0, 0); wait_frame();
    repeat (20) @(negedge clk);
    do_reset();                                     // abort mid-DROP
    idle_frames(2);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: idle_frames(1);
        1: press(1, 0, 0);
        2: press(0, 1, 0);
        3: press(1, 1, 0);
        4: press(1, 0, 1);
        default: idle_frames($urandom_range(1, 3));
      endcase
      if (i == 20) begin repeat ($urandom_range(5, 25)) @(negedge clk); do_reset(); end
    end
    if (m_frz) press(0, 1, 0);
    idle_frames(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
